// File: rtl/mskaes_128bits_inv_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mskaes_128bits_inv_round_ctrl_if
// Description : Handshake and datapath-control bundle between the masked
//               AES-128 inverse-round controller and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface mskaes_128bits_inv_round_ctrl_if #(
  parameter int d = 2
);
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             load;
  logic             round_en;
  logic             last_round;
  logic [8*d-1:0]   sh_RCON;
  logic             rnd_req;
  logic             cleaning_on;
  logic [3:0]       round_idx;

  // Controller side: sequences the masked datapath.
  modport master (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid,
    output load,
    output round_en,
    output last_round,
    output sh_RCON,
    output rnd_req,
    output cleaning_on,
    output round_idx
  );

  // Environment side: producer, consumer and datapath.
  modport slave (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  load,
    input  round_en,
    input  last_round,
    input  sh_RCON,
    input  rnd_req,
    input  cleaning_on,
    input  round_idx
  );
endinterface
`default_nettype wire

// File: rtl/mskaes_128bits_inv_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mskaes_128bits_inv_round_ctrl
// Description : Round sequencer for a masked AES-128 decryption datapath.
//               Loads a block, runs 10 inverse rounds of LATENCY cycles each,
//               presents the result, then flushes the masked pipeline with
//               shared zeros before accepting the next block.
// Revision    : 1.0 - initial release
// ============================================================================
module mskaes_128bits_inv_round_ctrl #(
  parameter int d       = 2,
  parameter int LATENCY = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  mskaes_128bits_inv_round_ctrl_if.master bus
);

  // LATENCY must fit the 4-bit latency counter.
  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
      $error("LATENCY must be in 1..15");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    DONE  = 3'd3,
    CLEAN = 3'd4
  } state_t;

  localparam logic [3:0] LAT_MAX   = 4'(LATENCY - 1);
  localparam logic [3:0] ROUNDS    = 4'd10;
  localparam logic [7:0] RCON_INIT = 8'h36;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] round_cnt;
  logic [3:0] lat_cnt;
  logic [7:0] rcon;
  logic       lat_last;

  assign lat_last = (lat_cnt == LAT_MAX);

  // Inverse of xtime in GF(2^8): walks the key-schedule constants backwards.
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    return r[0] ? ((r >> 1) ^ 8'h8D) : (r >> 1);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and per-state datapath controls.
  always_comb begin
    state_nxt       = state;
    bus.in_ready    = 1'b0;
    bus.out_valid   = 1'b0;
    bus.load        = 1'b0;
    bus.round_en    = 1'b0;
    bus.last_round  = 1'b0;
    bus.sh_RCON     = '0;
    bus.rnd_req     = 1'b0;
    bus.cleaning_on = 1'b0;
    bus.round_idx   = 4'd0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        bus.load  = 1'b1;
        state_nxt = ROUND;
      end
      ROUND: begin
        bus.rnd_req      = 1'b1;
        bus.round_idx    = round_cnt;
        bus.sh_RCON[7:0] = rcon;
        bus.last_round   = (round_cnt == 4'd1);
        bus.round_en     = lat_last;
        if (lat_last && round_cnt == 4'd1) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = CLEAN;
      end
      CLEAN: begin
        bus.cleaning_on = 1'b1;
        bus.rnd_req     = 1'b1;
        if (lat_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round counter, latency counter and round-constant register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_cnt <= 4'd0;
      lat_cnt   <= 4'd0;
      rcon      <= RCON_INIT;
    end else begin
      case (state)
        LOAD: begin
          round_cnt <= ROUNDS;
          lat_cnt   <= 4'd0;
          rcon      <= RCON_INIT;
        end
        ROUND: begin
          if (lat_last) begin
            lat_cnt   <= 4'd0;
            rcon      <= inv_xtime(rcon);
            round_cnt <= round_cnt - 4'd1;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        DONE:    lat_cnt <= 4'd0;
        CLEAN:   lat_cnt <= lat_last ? 4'd0 : lat_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mskaes_128bits_inv_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mskaes_128bits_inv_round_ctrl
// Description : Self-checking bench for the inverse-round controller; a
//               LATENCY=4 and a LATENCY=1 instance checked against a
//               cycle-timeline model of one block transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mskaes_128bits_inv_round_ctrl;

  localparam int D = 2;

  typedef struct packed {
    logic        in_ready;
    logic        load;
    logic        round_en;
    logic        last_round;
    logic        rnd_req;
    logic        cleaning_on;
    logic        out_valid;
    logic [3:0]  round_idx;
    logic [15:0] sh;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic iv [2];
  logic ordy [2];

  int checks = 0;
  int errors = 0;

  // Per-block observations collected by run_block.
  logic [7:0] cap_q [$];
  int n_en, n_ov, n_cl, first_en, first_ov;

  logic [7:0] rcon_tab [10] = '{8'h36, 8'h1B, 8'h80, 8'h40, 8'h20,
                                8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  always #5 clk = ~clk;

  mskaes_128bits_inv_round_ctrl_if #(.d(D)) bus4 ();
  mskaes_128bits_inv_round_ctrl_if #(.d(D)) bus1 ();

  assign bus4.in_valid  = iv[0];
  assign bus4.out_ready = ordy[0];
  assign bus1.in_valid  = iv[1];
  assign bus1.out_ready = ordy[1];

  mskaes_128bits_inv_round_ctrl #(.d(D), .LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.master));
  mskaes_128bits_inv_round_ctrl #(.d(D), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.master));

  function automatic obs_t get_obs(input int which);
    obs_t o;
    if (which == 0)
      o = {bus4.in_ready, bus4.load, bus4.round_en, bus4.last_round, bus4.rnd_req,
           bus4.cleaning_on, bus4.out_valid, bus4.round_idx, bus4.sh_RCON};
    else
      o = {bus1.in_ready, bus1.load, bus1.round_en, bus1.last_round, bus1.rnd_req,
           bus1.cleaning_on, bus1.out_valid, bus1.round_idx, bus1.sh_RCON};
    return o;
  endfunction

  function automatic obs_t idle_exp();
    obs_t e;
    e = '0;
    e.in_ready = 1'b1;
    return e;
  endfunction

  // Drives one block through a DUT and checks every cycle against the
  // transaction timeline: handshake at t=0, load at t=1, ten rounds of
  // lat cycles, DONE held for hold extra cycles, lat CLEAN cycles, IDLE.
  // Entered and left at posedge+1. chained: handshake already happened.
  // stop_at >= 0 returns early at the start of that cycle.
  task automatic run_block(input int which, input int lat, input int hold,
                           input bit chained, input bit next_chained, input int stop_at);
    int done_start, done_end, last_t;
    bit st_idle, st_round, st_done, st_clean;
    obs_t o, e;
    done_start = 2 + 10 * lat;
    done_end   = done_start + hold;
    last_t     = done_end + lat + 1;
    cap_q.delete();
    n_en = 0; n_ov = 0; n_cl = 0; first_en = -1; first_ov = -1;
    for (int t = (chained ? 1 : 0); t <= last_t; t++) begin
      if (stop_at >= 0 && t == stop_at) return;
      if (t == 0)           iv[which] = 1'b1;
      else if (t == last_t) iv[which] = next_chained;
      else                  iv[which] = 1'($urandom_range(0, 1));
      if (t < done_start || t > done_end) ordy[which] = 1'($urandom_range(0, 1));
      else                                ordy[which] = (t == done_end);
      @(negedge clk);
      st_idle  = (t == 0) || (t == last_t);
      st_round = (t >= 2) && (t < done_start);
      st_done  = (t >= done_start) && (t <= done_end);
      st_clean = (t > done_end) && (t < last_t);
      e = '0;
      e.in_ready    = st_idle;
      e.load        = (t == 1);
      e.round_en    = st_round && ((t - 1) % lat == 0);
      e.last_round  = st_round && (t >= 2 + 9 * lat);
      e.rnd_req     = st_round || st_clean;
      e.cleaning_on = st_clean;
      e.out_valid   = st_done;
      if (st_round) begin
        e.round_idx = 4'(10 - (t - 2) / lat);
        e.sh        = 16'(rcon_tab[(t - 2) / lat]);
      end
      o = get_obs(which);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL timeline dut%0d t=%0d got rdy/ld/en/last/rnd/cln/ov=%b idx=%0d sh=%h want %b idx=%0d sh=%h",
                 which, t, o[26:20], o.round_idx, o.sh, e[26:20], e.round_idx, e.sh);
      end
      checks++;
      if ($countones({o.load, o.round_en, o.out_valid, o.cleaning_on}) > 1) begin
        errors++;
        $display("FAIL exclusive dut%0d t=%0d got ld/en/ov/cln=%b want at most one set",
                 which, t, {o.load, o.round_en, o.out_valid, o.cleaning_on});
      end
      if (o.round_en === 1'b1) begin
        n_en++;
        cap_q.push_back(o.sh[7:0]);
        if (first_en < 0) first_en = t;
      end
      if (o.out_valid === 1'b1) begin
        n_ov++;
        if (first_ov < 0) first_ov = t;
      end
      if (o.cleaning_on === 1'b1) n_cl++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    obs_t o;
    #2;
    for (int w = 0; w < 2; w++) begin
      o = get_obs(w);
      checks++;
      if (o !== idle_exp()) begin
        errors++;
        $display("FAIL reset_values dut%0d got %h want %h", w, o, idle_exp());
      end
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_latency();
    bit seq_ok;
    run_block(0, 4, 0, 1'b0, 1'b0, -1);
    checks++;
    if (first_en != 5 || n_en != 10) begin
      errors++;
      $display("FAIL round_en_count got first=%0d n=%0d want first=5 n=10", first_en, n_en);
    end
    checks++;
    if (first_ov != 42 || n_ov != 1) begin
      errors++;
      $display("FAIL out_latency got first=%0d n=%0d want first=42 n=1", first_ov, n_ov);
    end
    seq_ok = (cap_q.size() == 10);
    for (int i = 0; i < cap_q.size() && i < 10; i++)
      if (cap_q[i] !== rcon_tab[i]) seq_ok = 1'b0;
    checks++;
    if (!seq_ok) begin
      errors++;
      $display("FAIL rcon_sequence got %p want %p", cap_q, rcon_tab);
    end
    checks++;
    if (n_cl != 4) begin
      errors++;
      $display("FAIL clean_len got %0d want 4", n_cl);
    end
  endtask

  task automatic test_hold();
    run_block(0, 4, 5, 1'b0, 1'b0, -1);
    checks++;
    if (n_ov != 6 || n_cl != 4) begin
      errors++;
      $display("FAIL hold_done got ov=%0d cln=%0d want ov=6 cln=4", n_ov, n_cl);
    end
  endtask

  task automatic test_back_to_back();
    run_block(0, 4, 0, 1'b0, 1'b1, -1);
    // Now at cycle 48 of the first block: the second load must be visible.
    #2;
    checks++;
    if (bus4.load !== 1'b1 || bus4.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load got load=%b rdy=%b want load=1 rdy=0", bus4.load, bus4.in_ready);
    end
    run_block(0, 4, int'($urandom_range(0, 3)), 1'b1, 1'b0, -1);
    checks++;
    if (first_ov != 42 || n_en != 10) begin
      errors++;
      $display("FAIL b2b_second got ov=%0d en=%0d want ov=42 en=10", first_ov, n_en);
    end
  endtask

  task automatic test_random();
    obs_t o;
    int gap;
    for (int k = 0; k < 4; k++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        iv[0] = 1'b0;
        ordy[0] = 1'($urandom_range(0, 1));
        @(negedge clk);
        o = get_obs(0);
        checks++;
        if (o !== idle_exp()) begin
          errors++;
          $display("FAIL idle_gap k=%0d got %h want %h", k, o, idle_exp());
        end
        @(posedge clk); #1;
      end
      run_block(0, 4, int'($urandom_range(0, 7)), 1'b0, 1'b0, -1);
    end
  endtask

  task automatic test_reset_abort();
    obs_t o;
    int stops [2] = '{20, 45};
    for (int s = 0; s < 2; s++) begin
      run_block(0, 4, 0, 1'b0, 1'b0, stops[s]);
      #2;
      iv[0]   = 1'b0;
      rst_n   = 1'b0;
      #1;
      o = get_obs(0);
      checks++;
      if (o !== idle_exp()) begin
        errors++;
        $display("FAIL async_reset stop=%0d got %h want %h", stops[s], o, idle_exp());
      end
      repeat (2) begin
        @(negedge clk);
        o = get_obs(0);
        checks++;
        if (o !== idle_exp()) begin
          errors++;
          $display("FAIL in_reset stop=%0d got %h want %h", stops[s], o, idle_exp());
        end
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      o = get_obs(0);
      checks++;
      if (o !== idle_exp()) begin
        errors++;
        $display("FAIL post_reset_idle stop=%0d got %h want %h", stops[s], o, idle_exp());
      end
      @(posedge clk); #1;
      run_block(0, 4, 0, 1'b0, 1'b0, -1);
      checks++;
      if (first_ov != 42) begin
        errors++;
        $display("FAIL post_reset_latency stop=%0d got %0d want 42", stops[s], first_ov);
      end
    end
  endtask

  task automatic test_latency1();
    bit seq_ok;
    run_block(1, 1, int'($urandom_range(0, 2)), 1'b0, 1'b0, -1);
    checks++;
    if (first_en != 2 || n_en != 10 || first_ov != 12 || n_cl != 1) begin
      errors++;
      $display("FAIL lat1_timing got en=%0d/%0d ov=%0d cln=%0d want en=2/10 ov=12 cln=1",
               first_en, n_en, first_ov, n_cl);
    end
    seq_ok = (cap_q.size() == 10);
    for (int i = 0; i < cap_q.size() && i < 10; i++)
      if (cap_q[i] !== rcon_tab[i]) seq_ok = 1'b0;
    checks++;
    if (!seq_ok) begin
      errors++;
      $display("FAIL lat1_rcon got %p want %p", cap_q, rcon_tab);
    end
  endtask

  initial begin
    iv[0] = 1'b0; iv[1] = 1'b0;
    ordy[0] = 1'b0; ordy[1] = 1'b0;
    test_reset();
    @(posedge clk); #1;
    test_latency();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_latency1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mskaes_128bits_inv_round_ctrl.md
MSKAES_128BITS_INV_ROUND_CTRL -- requirements
Module: mskaes_128bits_inv_round_ctrl

Interface
REQ-001 Parameter: d, default 2, number of shares carried on shared buses.
REQ-002 Parameter: LATENCY, default 4, pipeline depth in cycles of the masked inverse-round datapath; legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  masked ciphertext and last-round key present on datapath inputs.
REQ-006 Port: in_ready  output  1  controller can accept a new block.
REQ-007 Port: out_valid  output  1  masked plaintext valid on datapath output.
REQ-008 Port: out_ready  input  1  consumer accepts plaintext.
REQ-009 Port: load  output  1  datapath state/key registers take external inputs.
REQ-010 Port: round_en  output  1  datapath state/key registers capture round result.
REQ-011 Port: last_round  output  1  datapath bypasses InvMixColumns.
REQ-012 Port: sh_RCON  output  8*d  shared round constant: share 0 = RCON byte, all other shares zero.
REQ-013 Port: rnd_req  output  1  fresh RandomZw/RandomBw required this cycle.
REQ-014 Port: cleaning_on  output  1  datapath key/state inputs forced to shared zero.
REQ-015 Port: round_idx  output  4  current decryption round, 10 down to 1; 0 when not computing.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, ROUND, DONE, CLEAN.
REQ-017 IDLE: in_ready=1; in_valid=1 -> LOAD next cycle; else stay.
REQ-018 LOAD: one cycle; load=1; round counter set to 10, latency counter to 0, RCON register to 0x36; -> ROUND.
REQ-019 ROUND: rnd_req=1 every cycle; latency counter increments 0..LATENCY-1; round_en=1 only when counter = LATENCY-1, then counter wraps to 0.
REQ-020 On each round_en: RCON updates by inverse xtime (r odd: (r>>1) xor 0x8D; else r>>1), giving 36,1B,80,40,20,10,08,04,02,01; round counter decrements.
REQ-021 last_round=1 throughout ROUND while round counter = 1; on that round's round_en -> DONE.
REQ-022 Latency: handshake sampled in cycle 0 -> load in cycle 1 -> out_valid first high in cycle 2+10*LATENCY (42 for LATENCY=4).
REQ-023 DONE: out_valid=1, held with all other outputs static until out_ready=1; out_ready=1 -> CLEAN next cycle.
REQ-024 CLEAN: cleaning_on=1, rnd_req=1 for exactly LATENCY cycles (flushes masked pipeline), then -> IDLE.
REQ-025 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE is ignored.
REQ-026 load, round_en, out_valid, cleaning_on SHALL be mutually exclusive in every cycle.
REQ-027 out_ready outside DONE is ignored; out_ready held high yields a one-cycle DONE.
REQ-028 round_idx equals round counter in ROUND, 0 in all other states.
REQ-029 LATENCY=1: round_en high every ROUND cycle; output in cycle 12.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, counters 0, RCON register 0x36, in_ready=1, all other outputs 0 (sh_RCON all shares 0x00 outside ROUND).
REQ-031 Reset asserted mid-ROUND or mid-CLEAN SHALL abort without emitting round_en, out_valid or cleaning_on afterwards; first cycle after release is IDLE.
REQ-032 sh_RCON share 0 SHALL equal RCON register only in ROUND; zero in all other states.

Verification
REQ-033 LATENCY=4, single in_valid pulse at cycle 0 -> load at 1, round_en at 5,9,...,41, last_round 38..41, out_valid at 42.
REQ-034 Capture sh_RCON share 0 at each round_en -> 36,1B,80,40,20,10,08,04,02,01; shares 1..d-1 always 00.
REQ-035 out_ready held low 5 cycles after out_valid -> out_valid stays high 6 cycles, then cleaning_on high exactly 4 cycles, then in_ready=1.
REQ-036 in_valid held high continuously -> second load only after CLEAN ends (cycle 48 for LATENCY=4, out_ready high).
REQ-037 rst_n pulsed low at cycle 20 -> outputs at reset values immediately, no out_valid; new block afterwards completes with full 42-cycle latency.
REQ-038 LATENCY=1 build -> round_en cycles 2..11, out_valid at 12, cleaning_on one cycle.
